// File: rtl/uart_param.sv
// UART transceiver: parameterised baud divider, payload width, parity mode and stop bits.
// Tx drives start bit from the accept edge; tdata_ready low for the whole frame and requests made while busy are dropped. Rx pulses rdata_valid one cycle after the stop sample and has no backpressure.
module uart_param #(
  parameter int CLKS_PER_BIT = 108,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  input  logic [DATA_BITS-1:0] tdata,
  input  logic                 tdata_req,
  output logic                 tdata_ready,
  output logic                 uart_tx,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_valid,
  output logic                 frame_err,
  output logic                 parity_err
);

  generate
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 1023 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
      $error("uart_param: illegal parameter value");
    end
  endgenerate

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]      IDX_LAST  = 3'(DATA_BITS - 1);
  localparam logic            STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic            PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_HIGH} rx_state_t;

  tx_state_t            r_tx_state;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [2:0]           r_tx_idx;
  logic                 r_tx_stop_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx;
  logic                 r_tx_ready;
  logic                 w_tx_accept;
  logic                 w_tx_bit_end;

  assign w_tx_accept  = tdata_req & r_tx_ready;
  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state    <= T_IDLE;
      r_tx_cnt      <= '0;
      r_tx_idx      <= '0;
      r_tx_stop_idx <= 1'b0;
      r_tx_shift    <= '0;
      r_tx_par      <= 1'b0;
      r_tx          <= 1'b1;
      r_tx_ready    <= 1'b0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          r_tx       <= 1'b1;
          r_tx_ready <= 1'b1;
          if (w_tx_accept) begin
            r_tx_state <= T_START;
            r_tx_ready <= 1'b0;
            r_tx       <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_shift <= tdata;
            r_tx_par   <= (^tdata) ^ PAR_ODD;
          end
        end
        default: begin
          if (w_tx_bit_end) r_tx_cnt <= '0;
          else              r_tx_cnt <= r_tx_cnt + 1'b1;
          if (w_tx_bit_end) begin
            case (r_tx_state)
              T_START: begin
                r_tx_state <= T_DATA;
                r_tx_idx   <= '0;
                r_tx       <= r_tx_shift[0];
              end
              T_DATA: begin
                r_tx_shift <= r_tx_shift >> 1;
                if (r_tx_idx == IDX_LAST) begin
                  if (PARITY != 0) begin
                    r_tx_state <= T_PARITY;
                    r_tx       <= r_tx_par;
                  end else begin
                    r_tx_state    <= T_STOP;
                    r_tx          <= 1'b1;
                    r_tx_stop_idx <= 1'b0;
                  end
                end else begin
                  r_tx_idx <= r_tx_idx + 1'b1;
                  r_tx     <= r_tx_shift[1];
                end
              end
              T_PARITY: begin
                r_tx_state    <= T_STOP;
                r_tx          <= 1'b1;
                r_tx_stop_idx <= 1'b0;
              end
              T_STOP: begin
                // ready rises on the very edge that ends the last stop bit
                if (r_tx_stop_idx == STOP_LAST) begin
                  r_tx_state <= T_IDLE;
                  r_tx_ready <= 1'b1;
                end else begin
                  r_tx_stop_idx <= 1'b1;
                end
              end
              default: r_tx_state <= T_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  logic                 r_rx_meta;
  logic                 r_rx_s;
  rx_state_t            r_rx_state;
  logic [CNT_W-1:0]     r_rx_cnt;
  logic [2:0]           r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_acc;
  logic                 r_rx_par_err;
  logic [DATA_BITS-1:0] r_rdata;
  logic                 r_rdata_valid;
  logic                 r_frame_err;
  logic                 r_parity_err;
  logic                 w_rx_bit_end;

  assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state    <= R_IDLE;
      r_rx_cnt      <= '0;
      r_rx_idx      <= '0;
      r_rx_shift    <= '0;
      r_rx_par_acc  <= 1'b0;
      r_rx_par_err  <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      case (r_rx_state)
        R_IDLE: begin
          if (!r_rx_s) begin
            r_rx_state <= R_START;
            r_rx_cnt   <= '0;
          end
        end
        R_START: begin
          // resample mid start bit; a high line here is a glitch, not a frame
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_s) begin
              r_rx_state <= R_IDLE;
            end else begin
              r_rx_state   <= R_DATA;
              r_rx_idx     <= '0;
              r_rx_par_acc <= 1'b0;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt     <= '0;
            r_rx_shift   <= {r_rx_s, r_rx_shift[DATA_BITS-1:1]};
            r_rx_par_acc <= r_rx_par_acc ^ r_rx_s;
            if (r_rx_idx == IDX_LAST) begin
              r_rx_par_err <= 1'b0;
              r_rx_state   <= (PARITY != 0) ? R_PARITY : R_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_PARITY: begin
          if (w_rx_bit_end) begin
            r_rx_cnt     <= '0;
            r_rx_par_err <= r_rx_par_acc ^ r_rx_s ^ PAR_ODD;
            r_rx_state   <= R_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt      <= '0;
            r_rdata       <= r_rx_shift;
            r_rdata_valid <= 1'b1;
            r_frame_err   <= ~r_rx_s;
            r_parity_err  <= r_rx_par_err;
            r_rx_state    <= r_rx_s ? R_IDLE : R_WAIT_HIGH;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        R_WAIT_HIGH: begin
          if (r_rx_s) r_rx_state <= R_IDLE;
        end
        default: r_rx_state <= R_IDLE;
      endcase
    end
  end

  assign tdata_ready = r_tx_ready;
  assign uart_tx     = r_tx;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: three instances (8N1, 8E1 looped back, 8O2) checked every cycle
// against a frame-level model, plus literal expectations for the worked examples.
module tb_uart_param;
  localparam int CPB = 16;
  localparam int NI  = 3;

  function automatic int par_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 1);
  endfunction
  function automatic int stops_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] tx, rdy, req, vld, ferr, perr, rx_line;
  logic [7:0]    td [NI];
  logic [7:0]    rd [NI];

  always #5 clk = ~clk;

  uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n (
    .clk(clk), .rst(rst), .uart_rx(rx_line[0]), .tdata(td[0]), .tdata_req(req[0]),
    .tdata_ready(rdy[0]), .uart_tx(tx[0]), .rdata(rd[0]), .rdata_valid(vld[0]),
    .frame_err(ferr[0]), .parity_err(perr[0]));
  uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e (
    .clk(clk), .rst(rst), .uart_rx(tx[1] & rx_line[1]), .tdata(td[1]), .tdata_req(req[1]),
    .tdata_ready(rdy[1]), .uart_tx(tx[1]), .rdata(rd[1]), .rdata_valid(vld[1]),
    .frame_err(ferr[1]), .parity_err(perr[1]));
  uart_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u_o (
    .clk(clk), .rst(rst), .uart_rx(rx_line[2]), .tdata(td[2]), .tdata_req(req[2]),
    .tdata_ready(rdy[2]), .uart_tx(tx[2]), .rdata(rd[2]), .rdata_valid(vld[2]),
    .frame_err(ferr[2]), .parity_err(perr[2]));

  typedef struct packed {
    int         at;
    int         inst;
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            chk_en = 0;
  logic [NI-1:0] m_rdy, m_tx, m_busy;
  int            m_cnt [NI];
  int            m_len [NI];
  logic [11:0]   m_frame [NI];
  logic [7:0]    cap_d [NI];
  logic [NI-1:0] cap_fe, cap_pe;
  int            vcnt [NI];
  int            v1_prev = 0;
  int            v1_last = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-level model: a frame is a bit list held CPB cycles per entry from the accept edge.
  initial begin
    logic [11:0] f;
    int          n;
    m_rdy = '0; m_tx = '1; m_busy = '0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      for (int k = 0; k < NI; k++) begin
        if (rst) begin
          m_busy[k] = 1'b0; m_rdy[k] = 1'b0; m_tx[k] = 1'b1;
        end else if (m_busy[k]) begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == m_len[k] * CPB) begin
            m_busy[k] = 1'b0; m_rdy[k] = 1'b1; m_tx[k] = 1'b1;
          end else begin
            m_tx[k] = m_frame[k][m_cnt[k] / CPB];
          end
        end else if (req[k] && m_rdy[k]) begin
          f = '0; n = 1;
          for (int i = 0; i < 8; i++) begin f[n] = td[k][i]; n++; end
          if (par_of(k) != 0) begin f[n] = (^td[k]) ^ (par_of(k) == 1); n++; end
          for (int s = 0; s < stops_of(k); s++) begin f[n] = 1'b1; n++; end
          m_frame[k] = f; m_len[k] = n; m_cnt[k] = 0;
          m_busy[k] = 1'b1; m_rdy[k] = 1'b0; m_tx[k] = 1'b0;
          // looped-back line goes low one edge later; receiver adds 2 sync edges
          if (k == 1)
            q.push_back('{at: cyc + 1 + 2 + CPB / 2 + (8 + 1 + 1) * CPB, inst: 1,
                          d: td[1], fe: 1'b0, pe: 1'b0});
        end else begin
          m_rdy[k] = 1'b1; m_tx[k] = 1'b1;
        end
      end
      if (rst) begin
        chk_en = 1;
        q.delete();
      end
    end
  end

  // Compare process: every cycle, all outputs of all instances.
  initial begin
    bit matched [NI];
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        for (int k = 0; k < NI; k++) begin
          chk($sformatf("uart_tx[%0d]", k), tx[k], m_tx[k]);
          chk($sformatf("tdata_ready[%0d]", k), rdy[k], m_rdy[k]);
          matched[k] = 0;
          if (vld[k] === 1'b1) begin
            vcnt[k]++;
            cap_d[k] = rd[k]; cap_fe[k] = ferr[k]; cap_pe[k] = perr[k];
            if (k == 1) begin v1_prev = v1_last; v1_last = cyc; end
          end
        end
        for (int j = q.size() - 1; j >= 0; j--) begin
          if (q[j].at == cyc) begin
            chk($sformatf("rdata_valid[%0d]", q[j].inst), vld[q[j].inst], 1);
            chk($sformatf("rdata[%0d]", q[j].inst), rd[q[j].inst], q[j].d);
            chk($sformatf("frame_err[%0d]", q[j].inst), ferr[q[j].inst], q[j].fe);
            chk($sformatf("parity_err[%0d]", q[j].inst), perr[q[j].inst], q[j].pe);
            matched[q[j].inst] = 1;
            q.delete(j);
          end
        end
        for (int k = 0; k < NI; k++)
          if (!matched[k]) chk($sformatf("no_valid[%0d]", k), vld[k], 0);
      end
    end
  end

  task automatic send_rx(input int k, input logic [7:0] d, input logic bad_par,
                         input logic stop_v, input int hold);
    logic [11:0] f;
    int          n;
    int          p;
    p = par_of(k);
    f = '0; n = 1;
    for (int i = 0; i < 8; i++) begin f[n] = d[i]; n++; end
    if (p != 0) begin f[n] = (^d) ^ (p == 1) ^ bad_par; n++; end
    f[n] = stop_v; n++;
    q.push_back('{at: cyc + 1 + 2 + CPB / 2 + (8 + ((p != 0) ? 1 : 0) + 1) * CPB, inst: k,
                  d: d, fe: ~stop_v, pe: (p != 0) & bad_par});
    for (int b = 0; b < n; b++) begin
      rx_line[k] = f[b];
      tick(CPB);
    end
    if (!stop_v) tick(hold);
    rx_line[k] = 1'b1;
    tick(4);
  endtask

  initial begin
    logic [9:0]  seq_a5;
    logic [11:0] fr;
    int          low;
    int          n0;
    rx_line = '1; req = '0;
    for (int k = 0; k < NI; k++) begin td[k] = 8'h00; vcnt[k] = 0; end
    rst = 1'b1;
    tick(3);
    for (int k = 0; k < NI; k++) begin
      chk("rst_ready_low", rdy[k], 0);
      chk("rst_tx_high", tx[k], 1);
      chk("rst_rdata", rd[k], 0);
      chk("rst_flags", {vld[k], ferr[k], perr[k]}, 0);
    end
    rst = 1'b0;
    tick(1);
    chk("ready_after_release", rdy[0], 1);

    // 8N1 0xA5: line sequence 0,1,0,1,0,0,1,0,1,1
    seq_a5 = 10'h34A;
    td[0] = 8'hA5; req[0] = 1'b1;
    tick(1);
    req[0] = 1'b0;
    low = 0;
    for (int c = 0; c < 170; c++) begin
      if (c % 16 == 8 && c < 160) chk($sformatf("a5_bit%0d", c / 16), tx[0], seq_a5[c / 16]);
      if (!rdy[0]) low++;
      tick(1);
    end
    chk("a5_ready_low_cycles", low, 160);

    // 8E1 loopback, request held across two frames
    td[1] = 8'h3C; req[1] = 1'b1;
    for (int i = 0; i < 10 && rdy[1]; i++) tick(1);
    chk("lb_accept1", rdy[1], 0);
    td[1] = 8'hFF;
    for (int i = 0; i < 400 && !rdy[1]; i++) tick(1);
    chk("lb_ready_back", rdy[1], 1);
    for (int i = 0; i < 5 && rdy[1]; i++) tick(1);
    chk("lb_accept2", rdy[1], 0);
    req[1] = 1'b0;
    tick(190);
    chk("lb_valid_spacing", v1_last - v1_prev, 177);
    chk("lb_last_rdata", cap_d[1], 8'hFF);
    chk("lb_last_flags", {cap_fe[1], cap_pe[1]}, 0);

    // 8O2: wrong parity then correct parity, plus an odd-parity transmit
    send_rx(2, 8'h01, 1'b1, 1'b1, 0);
    chk("odd_bad_rdata", cap_d[2], 8'h01);
    chk("odd_bad_perr", cap_pe[2], 1);
    chk("odd_bad_ferr", cap_fe[2], 0);
    send_rx(2, 8'h01, 1'b0, 1'b1, 0);
    chk("odd_good_perr", cap_pe[2], 0);
    td[2] = 8'h01; req[2] = 1'b1;
    tick(1);
    req[2] = 1'b0;
    tick(11 * CPB + 5);

    // framing error with line held low, then a clean frame
    n0 = vcnt[0];
    send_rx(0, 8'h55, 1'b0, 1'b0, 100);
    chk("ferr_rdata", cap_d[0], 8'h55);
    chk("ferr_flag", cap_fe[0], 1);
    send_rx(0, 8'h12, 1'b0, 1'b1, 0);
    chk("after_break_rdata", cap_d[0], 8'h12);
    chk("after_break_ferr", cap_fe[0], 0);
    chk("break_valid_count", vcnt[0] - n0, 2);

    // 5-cycle glitch is a false start
    n0 = vcnt[0];
    rx_line[0] = 1'b0;
    tick(5);
    rx_line[0] = 1'b1;
    tick(60);
    chk("false_start_no_valid", vcnt[0] - n0, 0);

    // reset during tx data bit 3 and rx data bit 5
    n0 = vcnt[0];
    fr = {3'b111, 8'hC3, 1'b0};
    td[0] = 8'h3C;
    for (int c = 0; c < 102; c++) begin
      rx_line[0] = fr[c / 16];
      if (c == 30) req[0] = 1'b1;
      if (c == 31) req[0] = 1'b0;
      tick(1);
    end
    rst = 1'b1; rx_line[0] = 1'b1;
    tick(1);
    chk("midframe_rst_tx", tx[0], 1);
    chk("midframe_rst_ready", rdy[0], 0);
    tick(1);
    rst = 1'b0;
    tick(40);
    chk("midframe_rst_no_valid", vcnt[0] - n0, 0);
    send_rx(0, 8'h5A, 1'b0, 1'b1, 0);
    chk("post_rst_rdata", cap_d[0], 8'h5A);
    td[0] = 8'h96; req[0] = 1'b1;
    tick(1);
    req[0] = 1'b0;
    tick(10 * CPB + 5);

    tick(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: bench did not complete, got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
